// File: rtl/axi_read_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : axi_read_arbiter_rr
// Purpose  : Read-channel arbiter between READ_MASTERS cache/prefetch read
//            masters and one external AXI read port. Round-robin or fixed
//            priority address grant, hardware-assigned ARID (= master index),
//            one address register stage, RDATA_DEPTH-entry read-data FIFO
//            routed back to masters by RID.
//            Optional feature macro: ARB_OUTSTANDING_LIMIT_EN (per-master
//            outstanding-burst limit of MAX_OUTSTANDING).
// Revision : 1.0 - initial release
// ============================================================================
module axi_read_arbiter_rr #(
  parameter int READ_MASTERS    = 3,
  parameter int ROUND_ROBIN     = 1,
  parameter int RDATA_DEPTH     = 2,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  // external address channel
  output logic                             axi_arvalid,
  input  logic                             axi_arready,
  output logic [3:0]                       axi_arid,
  output logic [7:0]                       axi_arlen,
  output logic [ADDR_WIDTH-1:0]            axi_araddr,
  // external data channel
  input  logic                             axi_rvalid,
  output logic                             axi_rready,
  input  logic [3:0]                       axi_rid,
  input  logic                             axi_rlast,
  input  logic [DATA_WIDTH-1:0]            axi_rdata,
  // per-master address requests (flattened, master i at slice i)
  input  logic [READ_MASTERS-1:0]          mem_arvalid,
  output logic [READ_MASTERS-1:0]          mem_arready,
  input  logic [READ_MASTERS*8-1:0]        mem_arlen,
  input  logic [READ_MASTERS*ADDR_WIDTH-1:0] mem_araddr,
  // per-master responses: valid/ready per master, payload shared by all
  output logic [READ_MASTERS-1:0]          mem_rvalid,
  input  logic [READ_MASTERS-1:0]          mem_rready,
  output logic [3:0]                       mem_rid,
  output logic                             mem_rlast,
  output logic [DATA_WIDTH-1:0]            mem_rdata,
  // sticky: a beat arrived whose RID names no master
  output logic                             rid_error
);

  localparam int IDX_W = (READ_MASTERS > 1) ? $clog2(READ_MASTERS) : 1;
  localparam int PTR_W = $clog2(RDATA_DEPTH);

  // ---------------------------------------------------------------- address
  logic [READ_MASTERS-1:0] w_eligible;
  logic                    w_grant_valid;
  logic [IDX_W-1:0]        w_grant_idx;
  logic [7:0]              w_grant_len;
  logic [ADDR_WIDTH-1:0]   w_grant_addr;
  logic                    w_stage_ready;
  logic                    w_accept;
  int                      w_cand;

  logic [IDX_W-1:0]        r_last_grant;
  logic                    r_arvalid;
  logic [3:0]              r_arid;
  logic [7:0]              r_arlen;
  logic [ADDR_WIDTH-1:0]   r_araddr;

  // ---------------------------------------------------------------- data
  logic [3:0]              r_fifo_id   [RDATA_DEPTH];
  logic                    r_fifo_last [RDATA_DEPTH];
  logic [DATA_WIDTH-1:0]   r_fifo_data [RDATA_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [PTR_W:0]          r_count;
  logic                    r_rready;
  logic                    r_rid_error;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_head_valid;
  logic [3:0]              w_head_id;
  logic                    w_head_last;
  logic                    w_head_bad;
  logic                    w_target_ready;
  logic [PTR_W:0]          w_count_next;

`ifdef ARB_OUTSTANDING_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  logic [CNT_W-1:0] r_outstanding [READ_MASTERS];

  // A master sitting at its burst limit drops out of arbitration
  generate
    for (genvar i = 0; i < READ_MASTERS; i++) begin : g_eligible
      assign w_eligible[i] = mem_arvalid[i] &&
                             (r_outstanding[i] != CNT_W'(MAX_OUTSTANDING));
    end
  endgenerate
`else
  assign w_eligible = mem_arvalid;
`endif

  // The stage accepts a new request when empty or draining this cycle
  assign w_stage_ready = axi_arready || !r_arvalid;
  assign w_accept      = w_grant_valid && w_stage_ready;

  // Pick the winner: lowest eligible index, or first eligible after last grant
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    w_grant_len   = '0;
    w_grant_addr  = '0;
    w_cand        = 0;
    for (int k = 0; k < READ_MASTERS; k++) begin
      if (ROUND_ROBIN != 0) begin
        w_cand = (int'(r_last_grant) + 1 + k) % READ_MASTERS;
      end else begin
        w_cand = k;
      end
      if (!w_grant_valid && w_eligible[w_cand]) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = IDX_W'(w_cand);
        w_grant_len   = mem_arlen[w_cand*8 +: 8];
        w_grant_addr  = mem_araddr[w_cand*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Only the winner sees ARREADY, and only when the stage can take it
  generate
    for (genvar i = 0; i < READ_MASTERS; i++) begin : g_arready
      assign mem_arready[i] = w_stage_ready && w_grant_valid &&
                              (w_grant_idx == IDX_W'(i));
    end
  endgenerate

  // Round-robin pointer moves only on an accepted grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= IDX_W'(READ_MASTERS - 1);
    end else if (w_accept) begin
      r_last_grant <= w_grant_idx;
    end
  end

  // Address output stage; payload holds while the external slave stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arvalid <= 1'b0;
      r_arid    <= '0;
      r_arlen   <= '0;
      r_araddr  <= '0;
    end else if (w_accept) begin
      r_arvalid <= 1'b1;
      r_arid    <= 4'(w_grant_idx);
      r_arlen   <= w_grant_len;
      r_araddr  <= w_grant_addr;
    end else if (axi_arready) begin
      r_arvalid <= 1'b0;
    end
  end

  assign axi_arvalid = r_arvalid;
  assign axi_arid    = r_arid;
  assign axi_arlen   = r_arlen;
  assign axi_araddr  = r_araddr;

  // ---------------------------------------------------------------- R FIFO
  assign w_push       = axi_rvalid && r_rready;
  assign w_head_valid = (r_count != '0);
  assign w_head_id    = r_fifo_id[r_rd_ptr];
  assign w_head_last  = r_fifo_last[r_rd_ptr];
  // 5-bit compare so READ_MASTERS=16 does not wrap
  assign w_head_bad   = ({1'b0, w_head_id} >= 5'(READ_MASTERS));

  // RREADY of the master addressed by the head beat
  always_comb begin
    w_target_ready = 1'b0;
    for (int i = 0; i < READ_MASTERS; i++) begin
      if (mem_rready[i] && (w_head_id == 4'(i))) begin
        w_target_ready = 1'b1;
      end
    end
  end

  // Unroutable beats are dropped as soon as they reach the head
  assign w_pop        = w_head_valid && (w_head_bad || w_target_ready);
  assign w_count_next = r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);

  // Beat storage; contents are don't-care while the slot is empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_id[r_wr_ptr]   <= axi_rid;
      r_fifo_last[r_wr_ptr] <= axi_rlast;
      r_fifo_data[r_wr_ptr] <= axi_rdata;
    end
  end

  // FIFO pointers, occupancy and registered external RREADY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count  <= w_count_next;
      r_rready <= (w_count_next != (PTR_W+1)'(RDATA_DEPTH));
    end
  end

  // Sticky bad-RID flag, raised the cycle after the bad beat is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rid_error <= 1'b0;
    end else if (w_pop && w_head_bad) begin
      r_rid_error <= 1'b1;
    end
  end

  assign axi_rready = r_rready;
  assign rid_error  = r_rid_error;
  assign mem_rid    = w_head_id;
  assign mem_rlast  = w_head_last;
  assign mem_rdata  = r_fifo_data[r_rd_ptr];

  generate
    for (genvar i = 0; i < READ_MASTERS; i++) begin : g_rvalid
      assign mem_rvalid[i] = w_head_valid && (w_head_id == 4'(i));
    end
  endgenerate

`ifdef ARB_OUTSTANDING_LIMIT_EN
  // Bursts in flight: up on accepted grant, down on popped RLAST beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_MASTERS; i++) begin
        r_outstanding[i] <= '0;
      end
    end else begin
      for (int i = 0; i < READ_MASTERS; i++) begin
        if ((w_accept && (w_grant_idx == IDX_W'(i))) &&
            !(w_pop && !w_head_bad && w_head_last && (w_head_id == 4'(i)))) begin
          r_outstanding[i] <= r_outstanding[i] + 1'b1;
        end else if (!(w_accept && (w_grant_idx == IDX_W'(i))) &&
                     (w_pop && !w_head_bad && w_head_last && (w_head_id == 4'(i)))) begin
          r_outstanding[i] <= r_outstanding[i] - 1'b1;
        end
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_read_arbiter_rr
// Purpose  : Directed self-checking bench for axi_read_arbiter_rr. A
//            round-robin and a fixed-priority instance share every input.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_read_arbiter_rr;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [N-1:0]    mem_arvalid;
  logic [N-1:0]    mem_rready;
  logic [N*8-1:0]  mem_arlen;
  logic [N*AW-1:0] mem_araddr;
  logic            axi_arready;
  logic            axi_rvalid;
  logic [3:0]      axi_rid;
  logic            axi_rlast;
  logic [DW-1:0]   axi_rdata;

  logic          rr_arvalid, rr_rready, rr_mem_rlast, rr_rid_error;
  logic [3:0]    rr_arid, rr_mem_rid;
  logic [7:0]    rr_arlen;
  logic [AW-1:0] rr_araddr;
  logic [N-1:0]  rr_mem_arready, rr_mem_rvalid;
  logic [DW-1:0] rr_mem_rdata;

  logic          fp_arvalid, fp_rready, fp_mem_rlast, fp_rid_error;
  logic [3:0]    fp_arid, fp_mem_rid;
  logic [7:0]    fp_arlen;
  logic [AW-1:0] fp_araddr;
  logic [N-1:0]  fp_mem_arready, fp_mem_rvalid;
  logic [DW-1:0] fp_mem_rdata;

  logic [AW-1:0] addr_tbl [N];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_read_arbiter_rr #(
    .READ_MASTERS(N), .ROUND_ROBIN(1), .RDATA_DEPTH(2),
    .MAX_OUTSTANDING(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .axi_arvalid(rr_arvalid), .axi_arready(axi_arready), .axi_arid(rr_arid),
    .axi_arlen(rr_arlen), .axi_araddr(rr_araddr),
    .axi_rvalid(axi_rvalid), .axi_rready(rr_rready), .axi_rid(axi_rid),
    .axi_rlast(axi_rlast), .axi_rdata(axi_rdata),
    .mem_arvalid(mem_arvalid), .mem_arready(rr_mem_arready),
    .mem_arlen(mem_arlen), .mem_araddr(mem_araddr),
    .mem_rvalid(rr_mem_rvalid), .mem_rready(mem_rready), .mem_rid(rr_mem_rid),
    .mem_rlast(rr_mem_rlast), .mem_rdata(rr_mem_rdata), .rid_error(rr_rid_error)
  );

  axi_read_arbiter_rr #(
    .READ_MASTERS(N), .ROUND_ROBIN(0), .RDATA_DEPTH(2),
    .MAX_OUTSTANDING(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .axi_arvalid(fp_arvalid), .axi_arready(axi_arready), .axi_arid(fp_arid),
    .axi_arlen(fp_arlen), .axi_araddr(fp_araddr),
    .axi_rvalid(axi_rvalid), .axi_rready(fp_rready), .axi_rid(axi_rid),
    .axi_rlast(axi_rlast), .axi_rdata(axi_rdata),
    .mem_arvalid(mem_arvalid), .mem_arready(fp_mem_arready),
    .mem_arlen(mem_arlen), .mem_araddr(mem_araddr),
    .mem_rvalid(fp_mem_rvalid), .mem_rready(mem_rready), .mem_rid(fp_mem_rid),
    .mem_rlast(fp_mem_rlast), .mem_rdata(fp_mem_rdata), .rid_error(fp_rid_error)
  );

  task automatic drive_idle();
    mem_arvalid = '0;
    mem_rready  = '1;
    axi_arready = 1'b1;
    axi_rvalid  = 1'b0;
    axi_rid     = '0;
    axi_rlast   = 1'b0;
    axi_rdata   = '0;
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    drive_idle();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rr_arvalid !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%b exp=0", rr_arvalid); end
    checks++; if (rr_mem_rvalid !== 3'b000) begin failures++; $display("FAIL reset_rvalid got=%b exp=000", rr_mem_rvalid); end
    checks++; if (rr_rid_error !== 1'b0) begin failures++; $display("FAIL reset_rid_error got=%b exp=0", rr_rid_error); end
    checks++; if (rr_rready !== 1'b1) begin failures++; $display("FAIL reset_rready got=%b exp=1", rr_rready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // start a burst: stalled AR from master 1, one beat held for master 1
    mem_arvalid = 3'b010; axi_arready = 1'b0;
    axi_rvalid = 1'b1; axi_rid = 4'd1; axi_rdata = 32'hAAAA_0001; mem_rready = 3'b000;
    tick();
    mem_arvalid = '0; axi_rvalid = 1'b0;
    checks++; if (rr_arvalid !== 1'b1) begin failures++; $display("FAIL preburst_arvalid got=%b exp=1", rr_arvalid); end
    checks++; if (rr_mem_rvalid !== 3'b010) begin failures++; $display("FAIL preburst_rvalid got=%b exp=010", rr_mem_rvalid); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rr_arvalid !== 1'b0) begin failures++; $display("FAIL midburst_arvalid got=%b exp=0", rr_arvalid); end
    checks++; if (rr_mem_rvalid !== 3'b000) begin failures++; $display("FAIL midburst_rvalid got=%b exp=000", rr_mem_rvalid); end
    checks++; if (rr_rready !== 1'b1) begin failures++; $display("FAIL midburst_rready got=%b exp=1", rr_rready); end
    @(negedge clk);
    rst_n = 1'b1;
    drive_idle();
    mem_arvalid = 3'b111;
    #1;
    checks++; if (rr_mem_arready !== 3'b001) begin failures++; $display("FAIL first_arready got=%b exp=001", rr_mem_arready); end
    tick();
    checks++; if (rr_arid !== 4'd0 || rr_araddr !== addr_tbl[0]) begin failures++; $display("FAIL first_grant got id=%0d addr=%h exp id=0 addr=%h", rr_arid, rr_araddr, addr_tbl[0]); end
  endtask

  task automatic test_round_robin();
    apply_reset();
    mem_arvalid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++; if (rr_mem_arready !== 3'(1 << (k % 3))) begin failures++; $display("FAIL rr_arready k=%0d got=%b exp=%b", k, rr_mem_arready, 3'(1 << (k % 3))); end
      tick();
      checks++; if (rr_arvalid !== 1'b1 || rr_arid !== 4'(k % 3) || rr_araddr !== addr_tbl[k % 3] || rr_arlen !== 8'(k % 3 + 1)) begin
        failures++; $display("FAIL rr_grant k=%0d got v=%b id=%0d addr=%h len=%0d exp id=%0d addr=%h len=%0d",
                             k, rr_arvalid, rr_arid, rr_araddr, rr_arlen, k % 3, addr_tbl[k % 3], k % 3 + 1);
      end
    end
    // external stall: stage holds, no master sees ARREADY
    axi_arready = 1'b0;
    #1;
    checks++; if (rr_mem_arready !== 3'b000) begin failures++; $display("FAIL stall_arready got=%b exp=000", rr_mem_arready); end
    tick();
    checks++; if (rr_arvalid !== 1'b1 || rr_arid !== 4'd2 || rr_araddr !== addr_tbl[2]) begin failures++; $display("FAIL stall_hold got v=%b id=%0d exp v=1 id=2", rr_arvalid, rr_arid); end
    mem_arvalid = '0; axi_arready = 1'b1;
    tick();
    checks++; if (rr_arvalid !== 1'b0) begin failures++; $display("FAIL drain_arvalid got=%b exp=0", rr_arvalid); end
  endtask

  task automatic test_fixed_priority();
    apply_reset();
    mem_arvalid = 3'b101;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (fp_arvalid !== 1'b1 || fp_arid !== 4'd0) begin failures++; $display("FAIL fp_grant k=%0d got v=%b id=%0d exp id=0", k, fp_arvalid, fp_arid); end
    end
    mem_arvalid = 3'b100;
    #1;
    checks++; if (fp_mem_arready !== 3'b100) begin failures++; $display("FAIL fp_arready got=%b exp=100", fp_mem_arready); end
    tick();
    checks++; if (fp_arid !== 4'd2 || fp_araddr !== addr_tbl[2]) begin failures++; $display("FAIL fp_m2 got id=%0d addr=%h exp id=2 addr=%h", fp_arid, fp_araddr, addr_tbl[2]); end
    mem_arvalid = '0;
  endtask

  task automatic test_backpressure();
    apply_reset();
    mem_rready = 3'b011;
    axi_rvalid = 1'b1; axi_rid = 4'd2; axi_rdata = 32'hD000_0000; axi_rlast = 1'b0;
    tick();
    axi_rdata = 32'hD000_0001;
    checks++; if (rr_rready !== 1'b1 || rr_mem_rvalid !== 3'b100 || rr_mem_rdata !== 32'hD000_0000) begin
      failures++; $display("FAIL bp_first got rready=%b rvalid=%b data=%h exp 1 100 d0000000", rr_rready, rr_mem_rvalid, rr_mem_rdata);
    end
    tick();
    axi_rdata = 32'hD000_0002; axi_rlast = 1'b1;
    checks++; if (rr_rready !== 1'b0) begin failures++; $display("FAIL bp_full got rready=%b exp=0", rr_rready); end
    tick();
    checks++; if (rr_rready !== 1'b0 || rr_mem_rdata !== 32'hD000_0000) begin failures++; $display("FAIL bp_hold got rready=%b data=%h exp 0 d0000000", rr_rready, rr_mem_rdata); end
    mem_rready = 3'b111;
    tick();
    checks++; if (rr_rready !== 1'b1 || rr_mem_rdata !== 32'hD000_0001 || rr_mem_rvalid !== 3'b100) begin
      failures++; $display("FAIL bp_release got rready=%b data=%h rvalid=%b exp 1 d0000001 100", rr_rready, rr_mem_rdata, rr_mem_rvalid);
    end
    tick();
    axi_rvalid = 1'b0;
    checks++; if (rr_mem_rdata !== 32'hD000_0002 || rr_mem_rlast !== 1'b1 || rr_mem_rvalid !== 3'b100) begin
      failures++; $display("FAIL bp_third got data=%h last=%b rvalid=%b exp d0000002 1 100", rr_mem_rdata, rr_mem_rlast, rr_mem_rvalid);
    end
    tick();
    checks++; if (rr_mem_rvalid !== 3'b000 || rr_rready !== 1'b1) begin failures++; $display("FAIL bp_empty got rvalid=%b rready=%b exp 000 1", rr_mem_rvalid, rr_rready); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ids [3];
    logic [2:0]  hot [3];
    apply_reset();
    ids[0] = 4'd0; ids[1] = 4'd1; ids[2] = 4'd0;
    hot[0] = 3'b001; hot[1] = 3'b010; hot[2] = 3'b001;
    axi_rvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      axi_rid = ids[k]; axi_rdata = 32'hE000_0000 + 32'(k);
      tick();
      checks++; if (rr_mem_rvalid !== hot[k] || rr_mem_rdata !== 32'hE000_0000 + 32'(k) || rr_mem_rid !== ids[k]) begin
        failures++; $display("FAIL b2b k=%0d got rvalid=%b data=%h rid=%0d exp %b %h %0d", k, rr_mem_rvalid, rr_mem_rdata, rr_mem_rid, hot[k], 32'hE000_0000 + 32'(k), ids[k]);
      end
    end
    axi_rvalid = 1'b0;
    tick();
    checks++; if (rr_mem_rvalid !== 3'b000) begin failures++; $display("FAIL b2b_end got rvalid=%b exp 000", rr_mem_rvalid); end
  endtask

  task automatic test_bad_rid();
    apply_reset();
    axi_rvalid = 1'b1; axi_rid = 4'd5; axi_rdata = 32'hBAD0_0005;
    tick();
    axi_rvalid = 1'b0;
    checks++; if (rr_mem_rvalid !== 3'b000 || rr_rid_error !== 1'b0) begin failures++; $display("FAIL badrid_head got rvalid=%b err=%b exp 000 0", rr_mem_rvalid, rr_rid_error); end
    tick();
    checks++; if (rr_rid_error !== 1'b1 || rr_mem_rvalid !== 3'b000) begin failures++; $display("FAIL badrid_set got err=%b rvalid=%b exp 1 000", rr_rid_error, rr_mem_rvalid); end
    repeat (2) tick();
    checks++; if (rr_rid_error !== 1'b1 || rr_rready !== 1'b1) begin failures++; $display("FAIL badrid_sticky got err=%b rready=%b exp 1 1", rr_rid_error, rr_rready); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (rr_rid_error !== 1'b0) begin failures++; $display("FAIL badrid_reset got err=%b exp 0", rr_rid_error); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef ARB_OUTSTANDING_LIMIT_EN
  task automatic test_limit();
    apply_reset();
    mem_arvalid = 3'b010;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (rr_mem_arready !== 3'b010) begin failures++; $display("FAIL limit_accept k=%0d got=%b exp=010", k, rr_mem_arready); end
      tick();
    end
    checks++; if (rr_mem_arready !== 3'b000) begin failures++; $display("FAIL limit_block got=%b exp=000", rr_mem_arready); end
    axi_rvalid = 1'b1; axi_rid = 4'd1;
    for (int b = 0; b < 4; b++) begin
      axi_rlast = (b == 3);
      axi_rdata = 32'hC000_0000 + 32'(b);
      tick();
    end
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    checks++; if (rr_mem_arready !== 3'b000) begin failures++; $display("FAIL limit_before_pop got=%b exp=000", rr_mem_arready); end
    tick();
    checks++; if (rr_mem_arready !== 3'b010) begin failures++; $display("FAIL limit_release got=%b exp=010", rr_mem_arready); end
    tick();
    mem_arvalid = '0;
    checks++; if (rr_arvalid !== 1'b1 || rr_arid !== 4'd1) begin failures++; $display("FAIL limit_third got v=%b id=%0d exp 1 1", rr_arvalid, rr_arid); end
  endtask

  // counters must stay in 0..MAX_OUTSTANDING; an underflow wraps above it
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (dut_rr.r_outstanding[i] > 2) begin
          failures++; $display("FAIL outstanding_range m=%0d got=%0d exp<=2", i, dut_rr.r_outstanding[i]);
        end
      end
    end
  end
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      addr_tbl[i] = 32'h1000_0000 + 32'(i) * 32'h100;
      mem_araddr[i*AW +: AW] = addr_tbl[i];
      mem_arlen[i*8 +: 8]    = 8'(i + 1);
    end
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_backpressure();
    test_back_to_back();
    test_bad_rid();
`ifdef ARB_OUTSTANDING_LIMIT_EN
    test_limit();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
